// File: rtl/song_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : song_seq_ctrl_pkg
//  Description : Shared state encodings, rest code and default widths for the
//                song sequencer and the song library.
//  Revision    : 1.0 - initial release
// ============================================================================
package song_seq_ctrl_pkg;

    localparam int unsigned c_DEF_IDX_W  = 4;
    localparam int unsigned c_DEF_NOTE_W = 4;
    localparam int unsigned c_DEF_LEN_W  = 3;
    localparam int unsigned c_REST_NOTE  = 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_PLAY   = 3'd2,
        S_GAP    = 3'd3,
        S_PAUSED = 3'd4,
        S_DONE   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/song_seq_ctrl_beat_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : beat_tick_gen
//  Description : Beat prescaler; one-cycle tick every DIV cycles, with
//                synchronous clear and freeze.
//  Revision    : 1.0 - initial release
// ============================================================================
module beat_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic freeze_i,
    output logic term_o,
    output logic tick_o
);

    localparam int unsigned c_CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    assign term_o = (cnt_q == c_CNT_W'(DIV - 1));
    assign tick_o = term_o & ~clear_i & ~freeze_i;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (!freeze_i) begin
            cnt_d = term_o ? '0 : cnt_q + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/song_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : song_seq_ctrl
//  Description : Song playback sequencer: walks the library note index, holds
//                each note for its duration in beat ticks, inserts silent gaps,
//                and handles start/pause/stop. Define LOOP_PLAY_EN to repeat
//                the song until stopped.
//  Revision    : 1.0 - initial release
// ============================================================================
module song_seq_ctrl
    import song_seq_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned BEAT_HZ   = 16,
    parameter int unsigned IDX_W     = c_DEF_IDX_W,
    parameter int unsigned NOTE_W    = c_DEF_NOTE_W,
    parameter int unsigned LEN_W     = c_DEF_LEN_W,
    parameter int unsigned GAP_TICKS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [1:0]        song_select,
    output logic [1:0]        lib_sel,
    output logic [IDX_W-1:0]  lib_idx,
    input  logic [NOTE_W-1:0] lib_note,
    input  logic [LEN_W-1:0]  lib_len,
    input  logic              lib_last,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_valid,
    output logic              busy,
    output logic              paused,
    output logic              song_done
);

    localparam int unsigned c_TICK_DIV = CLK_HZ / BEAT_HZ;
    localparam int unsigned c_DUR_W    = LEN_W + 1;
    localparam int unsigned c_GAP_W    = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [NOTE_W-1:0] c_REST = NOTE_W'(c_REST_NOTE);

    state_t               state_q, state_d;
    state_t               ret_q, ret_d;
    logic [1:0]           sel_q, sel_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NOTE_W-1:0]    note_q, note_d;
    logic [NOTE_W-1:0]    cap_q, cap_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 last_q, last_d;
    logic [c_DUR_W-1:0]   dur_q, dur_d;
    logic [c_GAP_W-1:0]   gap_q, gap_d;
    logic                 next_step;

    logic w_tick;
    logic w_term;
    logic w_pause_take;
    logic w_presc_clr;
    logic w_presc_frz;

    assign w_pause_take = pause & ~stop & ((state_q == S_PLAY) | (state_q == S_GAP));
    assign w_presc_clr  = (state_q == S_FETCH) | ((state_q == S_IDLE) & start & ~stop);
    // A pause landing on the terminal count holds it so the beat is not lost.
    assign w_presc_frz  = (state_q == S_PAUSED) | (w_pause_take & w_term);

    beat_tick_gen #(
        .DIV (c_TICK_DIV)
    ) u_beat_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (w_presc_clr),
        .freeze_i (w_presc_frz),
        .term_o   (w_term),
        .tick_o   (w_tick)
    );

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        note_d    = note_q;
        cap_d     = cap_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        last_d    = last_q;
        dur_d     = dur_q;
        gap_d     = gap_q;
        next_step = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
            sel_d   = '0;
            idx_d   = '0;
            note_d  = c_REST;
            valid_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sel_d   = song_select;
                        idx_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    note_d  = lib_note;
                    cap_d   = lib_note;
                    dur_d   = c_DUR_W'(lib_len) + c_DUR_W'(1);
                    last_d  = lib_last;
                    valid_d = 1'b1;
                    state_d = S_PLAY;
                end
                S_PLAY: begin
                    if (w_pause_take) begin
                        ret_d   = S_PLAY;
                        state_d = S_PAUSED;
                        valid_d = 1'b0;
                        note_d  = c_REST;
                    end else if (w_tick) begin
                        if (dur_q == c_DUR_W'(1)) begin
                            valid_d = 1'b0;
                            note_d  = c_REST;
                            if (GAP_TICKS > 0) begin
                                gap_d   = c_GAP_W'(GAP_TICKS);
                                state_d = S_GAP;
                            end else begin
                                next_step = 1'b1;
                            end
                        end else begin
                            dur_d = dur_q - c_DUR_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (w_pause_take) begin
                        ret_d   = S_GAP;
                        state_d = S_PAUSED;
                    end else if (w_tick) begin
                        if (gap_q == c_GAP_W'(1)) begin
                            next_step = 1'b1;
                        end else begin
                            gap_d = gap_q - c_GAP_W'(1);
                        end
                    end
                end
                S_PAUSED: begin
                    if (pause) begin
                        state_d = ret_q;
                        if (ret_q == S_PLAY) begin
                            valid_d = 1'b1;
                            note_d  = cap_q;
                        end
                    end
                end
                S_DONE: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // The all-ones index guard stops a song whose last flag never comes.
            if (next_step) begin
                if (last_q || (idx_q == '1)) begin
`ifdef LOOP_PLAY_EN
                    idx_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_FETCH;
`else
                    done_d  = 1'b1;
                    state_d = S_DONE;
`endif
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_FETCH;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ret_q   <= S_IDLE;
            sel_q   <= '0;
            idx_q   <= '0;
            note_q  <= '0;
            cap_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
            dur_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            note_q  <= note_d;
            cap_q   <= cap_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            last_q  <= last_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
        end
    end

    assign lib_sel    = sel_q;
    assign lib_idx    = idx_q;
    assign note_out   = note_q;
    assign note_valid = valid_q;
    assign busy       = busy_q;
    assign paused     = (state_q == S_PAUSED);
    assign song_done  = done_q;

endmodule
`default_nettype wire
